fetch_sequencer: RTL

- Sequences the program counter register and the instruction-memory fetch port of the ARM core.
- Produces the PC register's next-value input every cycle: hold, +4, branch target, exception vector, or reset vector.
- Issues req/ack fetches to instruction memory and presents fetched words downstream with a valid/ready handshake.
- Flushes in-flight or buffered instructions on redirect, and counts delivered instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0004;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// PC next-value generation and instruction-memory fetch sequencing with a
// one-entry output buffer, redirect flushing and delivered-instruction count.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        exc_valid,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic         req_active_q, req_active_d;
  logic         flush_pending_q, flush_pending_d;
  logic         instr_valid_d;
  logic [31:0]  instr_out_d, instr_pc_d, fetch_count_d;
  logic         redirect;
  logic [31:0]  target;

  assign imem_addr = pc_cur;
  assign redirect  = exc_valid | branch_valid;
  assign target    = exc_valid ? EXC_VECTOR : align_word(branch_target);

  always_comb begin
    state_d         = state_q;
    req_active_d    = req_active_q;
    flush_pending_d = flush_pending_q;
    instr_valid_d   = instr_valid;
    instr_out_d     = instr_out;
    instr_pc_d      = instr_pc;
    fetch_count_d   = fetch_count;
    pc_next         = pc_cur;
    imem_req        = 1'b0;

    case (state_q)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_d = FETCH;
      end
      FETCH: begin
        if (!req_active_q) begin
          if (redirect) begin
            pc_next = target;
          end else if (!stall) begin
            imem_req     = 1'b1;
            req_active_d = 1'b1;
          end
        end else begin
          // An issued request is never retracted; a redirect only marks the
          // outstanding word for discard when it finally arrives.
          imem_req = 1'b1;
          if (imem_ack) begin
            req_active_d = 1'b0;
            if (flush_pending_q || redirect) begin
              flush_pending_d = 1'b0;
              if (redirect) pc_next = target;
            end else begin
              instr_out_d   = imem_rdata;
              instr_pc_d    = pc_cur;
              instr_valid_d = 1'b1;
              pc_next       = pc_cur + 32'(PC_STEP);
              state_d       = HOLD;
            end
          end else if (redirect) begin
            pc_next         = target;
            flush_pending_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_next       = target;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          fetch_count_d = fetch_count + 32'd1;
          state_d       = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= BOOT;
      req_active_q    <= 1'b0;
      flush_pending_q <= 1'b0;
      instr_valid     <= 1'b0;
      instr_out       <= '0;
      instr_pc        <= '0;
      fetch_count     <= '0;
    end else begin
      state_q         <= state_d;
      req_active_q    <= req_active_d;
      flush_pending_q <= flush_pending_d;
      instr_valid     <= instr_valid_d;
      instr_out       <= instr_out_d;
      instr_pc        <= instr_pc_d;
      fetch_count     <= fetch_count_d;
    end
  end

endmodule
